control_unit: RTL and testbench

Multi-cycle sequencer for the 16-bit accumulator CPU. It drives the instruction-fetch / decode / execute loop around the instruction register, program counter, accumulator, ALU and a handshaked memory port. It generates `loadIR` and waits for the instruction register's two-edge load-to-output latency before decoding `opcode`. It also keeps a retired-instruction counter for debug and benches.

---
 rtl/control_unit_pkg.sv | 38 +++
 rtl/control_unit_retire_counter.sv | 22 ++
 rtl/control_unit.sv | 125 ++++++++++++
 tb/tb_control_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared widths, state encoding and opcode map for the accumulator CPU.
package CPU_package;

  localparam int unsigned DATA_WIDTH    = 16;
  localparam int unsigned ADDRESS_WIDTH = 12;
  localparam int unsigned ALU_OPCODE    = 3;
  localparam int unsigned OP_W          = ALU_OPCODE + 1;

  typedef enum logic [3:0] {
    CU_IDLE    = 4'd0,
    CU_FETCH   = 4'd1,
    CU_LOAD_IR = 4'd2,
    CU_IR_WAIT = 4'd3,
    CU_DECODE  = 4'd4,
    CU_MEM_RD  = 4'd5,
    CU_EXEC    = 4'd6,
    CU_STORE   = 4'd7,
    CU_RETIRE  = 4'd8,
    CU_HALT    = 4'd9
  } cu_state_t;

  // 0xB..0xE are reserved and behave as NOP
  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_STA = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_XOR = 4'h7,
    OP_NOT = 4'h8,
    OP_JMP = 4'h9,
    OP_JZ  = 4'hA,
    OP_HLT = 4'hF
  } opcode_t;

endpackage

// File: rtl/control_unit_retire_counter.sv
// Wrapping retired-instruction counter with enable and synchronous clear.
module retire_counter
  import CPU_package::*;
#(
  parameter int unsigned W = DATA_WIDTH
) (
  input  logic         iclk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear has priority; otherwise count up by one when enabled, wrapping naturally
  always_ff @(posedge iclk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator CPU.
module control_unit
  import CPU_package::*;
(
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  run,
  input  logic [OP_W-1:0]       opcode,
  input  logic                  acc_zero,
  input  logic                  mem_ready,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  addr_sel,
  output logic                  loadIR,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  acc_load,
  output logic                  acc_src,
  output logic [OP_W-1:0]       alu_op,
  output logic                  halted,
  output logic [DATA_WIDTH-1:0] retired
);

  cu_state_t       state;
  cu_state_t       state_nxt;
  logic [OP_W-1:0] op_q;

  // State register and opcode latch; opcode is captured while decoding
  always_ff @(posedge iclk) begin
    if (irst) begin
      state <= CU_IDLE;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == CU_DECODE) begin
        op_q <= opcode;
      end
    end
  end

  // Next-state and output decode from the current state
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    addr_sel  = 1'b0;
    loadIR    = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    acc_load  = 1'b0;
    acc_src   = 1'b0;
    alu_op    = '0;
    halted    = 1'b0;
    case (state)
      CU_IDLE: begin
        if (run) state_nxt = CU_FETCH;
      end
      CU_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) state_nxt = CU_LOAD_IR;
      end
      CU_LOAD_IR: begin
        loadIR    = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = CU_IR_WAIT;
      end
      // Bubble so the IR output register holds the new instruction
      CU_IR_WAIT: begin
        state_nxt = CU_DECODE;
      end
      CU_DECODE: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_nxt = CU_MEM_RD;
          OP_STA: state_nxt = CU_STORE;
          OP_NOT: state_nxt = CU_EXEC;
          OP_JMP: begin
            pc_load   = 1'b1;
            state_nxt = CU_RETIRE;
          end
          OP_JZ: begin
            pc_load   = acc_zero;
            state_nxt = CU_RETIRE;
          end
          OP_HLT: state_nxt = CU_HALT;
          default: state_nxt = CU_RETIRE;
        endcase
      end
      CU_MEM_RD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) state_nxt = CU_EXEC;
      end
      CU_EXEC: begin
        acc_load  = 1'b1;
        alu_op    = op_q;
        acc_src   = (op_q == OP_LDA);
        state_nxt = CU_RETIRE;
      end
      CU_STORE: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) state_nxt = CU_RETIRE;
      end
      CU_RETIRE: begin
        state_nxt = CU_FETCH;
      end
      CU_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = CU_IDLE;
      end
    endcase
  end

  retire_counter #(
    .W (DATA_WIDTH)
  ) u_retire (
    .iclk  (iclk),
    .clr   (irst),
    .en    (state == CU_RETIRE),
    .count (retired)
  );

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for the control_unit sequencer.
module tb_control_unit;

  logic        iclk;
  logic        irst;
  logic        run;
  logic [3:0]  opcode;
  logic        acc_zero;
  logic        mem_ready;
  logic        mem_rd;
  logic        mem_wr;
  logic        addr_sel;
  logic        loadIR;
  logic        pc_inc;
  logic        pc_load;
  logic        acc_load;
  logic        acc_src;
  logic [3:0]  alu_op;
  logic        halted;
  logic [15:0] retired;

  int vecs  = 0;
  int fails = 0;

  control_unit dut (
    .iclk      (iclk),
    .irst      (irst),
    .run       (run),
    .opcode    (opcode),
    .acc_zero  (acc_zero),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .addr_sel  (addr_sel),
    .loadIR    (loadIR),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .acc_load  (acc_load),
    .acc_src   (acc_src),
    .alu_op    (alu_op),
    .halted    (halted),
    .retired   (retired)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Output vector: {mem_rd, mem_wr, addr_sel, loadIR, pc_inc, pc_load, acc_load, acc_src, alu_op[3:0], halted}
  function automatic logic [12:0] outs();
    return {mem_rd, mem_wr, addr_sel, loadIR, pc_inc, pc_load, acc_load, acc_src, alu_op, halted};
  endfunction

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic do_reset();
    irst      = 1'b1;
    run       = 1'b0;
    opcode    = 4'h0;
    acc_zero  = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    irst = 1'b0;
  endtask

  task automatic test_reset();
    irst = 1'b1; run = 1'b1; mem_ready = 1'b1; opcode = 4'h0; acc_zero = 1'b0;
    tick();
    tick();
    vecs++;
    if (outs() !== 13'h0000) begin fails++; $display("FAIL reset_outs got %h want %h", outs(), 13'h0000); end
    vecs++;
    if (retired !== 16'h0000) begin fails++; $display("FAIL reset_retired got %h want %h", retired, 16'h0000); end
    irst = 1'b0; run = 1'b0;
    tick();
    vecs++;
    if (outs() !== 13'h0000) begin fails++; $display("FAIL idle_no_run got %h want %h", outs(), 13'h0000); end
  endtask

  task automatic test_nop();
    logic [12:0] e [6]  = '{13'h1000, 13'h0300, 13'h0000, 13'h0000, 13'h0000, 13'h1000};
    logic [15:0] rt [6] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1};
    do_reset();
    opcode = 4'h0; mem_ready = 1'b1; run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      run = 1'b0;
      vecs++;
      if (outs() !== e[i]) begin fails++; $display("FAIL nop_outs cyc%0d got %h want %h", i, outs(), e[i]); end
      vecs++;
      if (retired !== rt[i]) begin fails++; $display("FAIL nop_retired cyc%0d got %h want %h", i, retired, rt[i]); end
    end
  endtask

  task automatic test_lda_wait();
    logic [12:0] e [10] = '{13'h1000, 13'h0300, 13'h0000, 13'h0000, 13'h1400,
                            13'h1400, 13'h1400, 13'h0062, 13'h0000, 13'h1000};
    logic        r [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    opcode = 4'h1; run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      run = 1'b0;
      mem_ready = r[i];
      vecs++;
      if (outs() !== e[i]) begin fails++; $display("FAIL lda_wait cyc%0d got %h want %h", i, outs(), e[i]); end
    end
  endtask

  task automatic test_add_single();
    logic [12:0] e [8] = '{13'h1000, 13'h0300, 13'h0000, 13'h0000, 13'h1400,
                           13'h0046, 13'h0000, 13'h1000};
    do_reset();
    opcode = 4'h3; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      run = 1'b0;
      vecs++;
      if (outs() !== e[i]) begin fails++; $display("FAIL add cyc%0d got %h want %h", i, outs(), e[i]); end
    end
  endtask

  task automatic test_not_latched();
    logic [12:0] e [7] = '{13'h1000, 13'h0300, 13'h0000, 13'h0000, 13'h0050, 13'h0000, 13'h1000};
    do_reset();
    opcode = 4'h8; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      run = 1'b0;
      if (i == 4) opcode = 4'h1;
      vecs++;
      if (outs() !== e[i]) begin fails++; $display("FAIL not_latch cyc%0d got %h want %h", i, outs(), e[i]); end
    end
  endtask

  task automatic test_sta();
    logic [12:0] e [8] = '{13'h1000, 13'h0300, 13'h0000, 13'h0000, 13'h0C00,
                           13'h0C00, 13'h0000, 13'h1000};
    logic        r [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    opcode = 4'h2; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      run = 1'b0;
      mem_ready = r[i];
      vecs++;
      if (outs() !== e[i]) begin fails++; $display("FAIL sta cyc%0d got %h want %h", i, outs(), e[i]); end
    end
    vecs++;
    if (retired !== 16'h0001) begin fails++; $display("FAIL sta_retired got %h want %h", retired, 16'h0001); end
  endtask

  task automatic test_jz();
    logic [12:0] e [11] = '{13'h1000, 13'h0300, 13'h0000, 13'h0080, 13'h0000, 13'h1000,
                            13'h0300, 13'h0000, 13'h0000, 13'h0000, 13'h1000};
    do_reset();
    opcode = 4'hA; acc_zero = 1'b1; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      run = 1'b0;
      if (i == 5) acc_zero = 1'b0;
      vecs++;
      if (outs() !== e[i]) begin fails++; $display("FAIL jz cyc%0d got %h want %h", i, outs(), e[i]); end
    end
    vecs++;
    if (retired !== 16'h0002) begin fails++; $display("FAIL jz_retired got %h want %h", retired, 16'h0002); end
  endtask

  task automatic test_jmp_reserved();
    logic [12:0] e [11] = '{13'h1000, 13'h0300, 13'h0000, 13'h0080, 13'h0000, 13'h1000,
                            13'h0300, 13'h0000, 13'h0000, 13'h0000, 13'h1000};
    do_reset();
    opcode = 4'h9; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      run = 1'b0;
      if (i == 5) opcode = 4'hC;
      vecs++;
      if (outs() !== e[i]) begin fails++; $display("FAIL jmp_rsv cyc%0d got %h want %h", i, outs(), e[i]); end
    end
    vecs++;
    if (retired !== 16'h0002) begin fails++; $display("FAIL jmp_rsv_retired got %h want %h", retired, 16'h0002); end
  endtask

  task automatic test_halt();
    logic [12:0] e [10] = '{13'h1000, 13'h0300, 13'h0000, 13'h0000, 13'h0000,
                            13'h1000, 13'h0300, 13'h0000, 13'h0000, 13'h0001};
    do_reset();
    opcode = 4'h0; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      run = 1'b0;
      if (i == 5) opcode = 4'hF;
      vecs++;
      if (outs() !== e[i]) begin fails++; $display("FAIL hlt_seq cyc%0d got %h want %h", i, outs(), e[i]); end
    end
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      tick();
      vecs++;
      if (outs() !== 13'h0001) begin fails++; $display("FAIL hlt_hold cyc%0d got %h want %h", i, outs(), 13'h0001); end
      vecs++;
      if (retired !== 16'h0001) begin fails++; $display("FAIL hlt_retired cyc%0d got %h want %h", i, retired, 16'h0001); end
    end
    run = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [12:0] e [7] = '{13'h1000, 13'h0300, 13'h0000, 13'h0000, 13'h0000, 13'h1000, 13'h1000};
    logic        r [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    opcode = 4'h0; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      mem_ready = r[i];
      vecs++;
      if (outs() !== e[i]) begin fails++; $display("FAIL rst_wait_seq cyc%0d got %h want %h", i, outs(), e[i]); end
    end
    vecs++;
    if (retired !== 16'h0001) begin fails++; $display("FAIL rst_wait_pre got %h want %h", retired, 16'h0001); end
    irst = 1'b1;
    tick();
    irst = 1'b0; run = 1'b0; mem_ready = 1'b1;
    vecs++;
    if (outs() !== 13'h0000) begin fails++; $display("FAIL rst_wait_outs got %h want %h", outs(), 13'h0000); end
    vecs++;
    if (retired !== 16'h0000) begin fails++; $display("FAIL rst_wait_retired got %h want %h", retired, 16'h0000); end
    tick();
    vecs++;
    if (outs() !== 13'h0000) begin fails++; $display("FAIL rst_wait_idle got %h want %h", outs(), 13'h0000); end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.u_retire.count = 16'hFFFF;
    tick();
    release dut.u_retire.count;
    tick();
    vecs++;
    if (retired !== 16'hFFFF) begin fails++; $display("FAIL wrap_preset got %h want %h", retired, 16'hFFFF); end
    opcode = 4'h0; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      run = 1'b0;
    end
    vecs++;
    if (retired !== 16'hFFFF) begin fails++; $display("FAIL wrap_in_retire got %h want %h", retired, 16'hFFFF); end
    tick();
    vecs++;
    if (retired !== 16'h0000) begin fails++; $display("FAIL wrap_result got %h want %h", retired, 16'h0000); end
    vecs++;
    if (outs() !== 13'h1000) begin fails++; $display("FAIL wrap_fetch got %h want %h", outs(), 13'h1000); end
  endtask

  initial begin
    irst = 1'b1; run = 1'b0; opcode = 4'h0; acc_zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_nop();
    test_lda_wait();
    test_add_single();
    test_not_latched();
    test_sta();
    test_jz();
    test_jmp_reserved();
    test_halt();
    test_reset_in_wait();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
